vpu_iter_ctrl: RTL and testbench

Iteration sequencer for the VPU datapath of the GF(257) 4x24 LDPC decoder. It accepts a start request and drives the `en` input of the VPU address generator. Each decoding iteration consists of one contiguous `en`-high sweep of Z cycles followed by an `en`-low drain, which also reloads the generator's row start addresses. After every iteration the block checks the syndrome result, stops early on success or at the iteration limit, and reports completion with a one-cycle done pulse.

---
 rtl/vpu_iter_ctrl.sv | 138 +++++++++++++
 tb/tb_vpu_iter_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vpu_iter_ctrl.sv
// vpu_iter_ctrl: iteration sequencer for the VPU datapath of the GF(257)
// 4x24 LDPC decoder. After a start request it runs decoding iterations until
// the syndrome check passes or the iteration limit is reached. Each iteration
// has three parts:
//   - an en-high sweep of Z cycles that drives the address generator,
//   - an en-low drain of DRAIN cycles, during which the generator reloads its
//     row start addresses,
//   - a single CHECK cycle that samples the syndrome.
// A one-cycle done pulse reports the end of the codeword.
//
// Ports
//   clk_i          clock, all flops rising-edge
//   rst_ni         asynchronous active-low reset
//   start_i        start request, only honoured in IDLE
//   abort_i        synchronous abort, wins over everything outside IDLE
//   syndrome_ok_i  parity checks satisfied, only sampled in CHECK
//   addr_en_o      address generator enable, high exactly in RUN
//   first_iter_o   high during RUN of iteration 0 (channel LLR select)
//   busy_o         high in every state except IDLE
//   done_o         one-cycle completion pulse
//   success_o      syndrome result captured in the final CHECK
//   iter_cnt_o     0-based index of the current or last iteration
module vpu_iter_ctrl #(
  parameter int unsigned Z        = 256,  // 2..511
  parameter int unsigned DRAIN    = 6,    // 1..255
  parameter int unsigned MAX_ITER = 10    // 1..31
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       syndrome_ok_i,
  output logic       addr_en_o,
  output logic       first_iter_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       success_o,
  output logic [4:0] iter_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [8:0] CYC_LAST  = 9'(Z - 1);
  localparam logic [7:0] DRN_LAST  = 8'(DRAIN - 1);
  localparam logic [4:0] ITER_LAST = 5'(MAX_ITER - 1);

  logic [2:0] state_q, state_d;
  logic [8:0] cyc_q,   cyc_d;
  logic [7:0] drn_q,   drn_d;
  logic [4:0] iter_q,  iter_d;
  logic       succ_q,  succ_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    drn_d   = drn_q;
    iter_d  = iter_q;
    succ_d  = succ_q;
    if (state_q != S_IDLE && abort_i) begin
      // Abort drops everything, including a pending done pulse.
      state_d = S_IDLE;
      cyc_d   = '0;
      drn_d   = '0;
      iter_d  = '0;
      succ_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_RUN;
            cyc_d   = '0;
            drn_d   = '0;
            iter_d  = '0;
            succ_d  = 1'b0;
          end
        end
        S_RUN: begin
          if (cyc_q == CYC_LAST) begin
            state_d = S_DRAIN;
            cyc_d   = '0;
            drn_d   = '0;
          end else begin
            cyc_d = cyc_q + 9'd1;
          end
        end
        S_DRAIN: begin
          // Clearing at the terminal count keeps the counter from passing it.
          if (drn_q == DRN_LAST) begin
            state_d = S_CHECK;
            drn_d   = '0;
          end else begin
            drn_d = drn_q + 8'd1;
          end
        end
        S_CHECK: begin
          succ_d = syndrome_ok_i;
          if (syndrome_ok_i || iter_q == ITER_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            iter_d  = iter_q + 5'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      drn_q   <= '0;
      iter_q  <= '0;
      succ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      drn_q   <= drn_d;
      iter_q  <= iter_d;
      succ_q  <= succ_d;
    end
  end

  // Moore outputs, decoded only from registered state.
  assign addr_en_o    = (state_q == S_RUN);
  assign first_iter_o = (state_q == S_RUN) && (iter_q == 5'd0);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign success_o    = succ_q;
  assign iter_cnt_o   = iter_q;

endmodule

// File: tb/tb_vpu_iter_ctrl.sv
module tb_vpu_iter_ctrl;
  localparam int Z  = 4;
  localparam int D  = 2;
  localparam int MI = 3;
  localparam int P  = Z + D + 1;  // cycles per iteration

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, syn = 1'b0;
  logic       addr_en, first_iter, busy, done, success;
  logic [4:0] iter_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vpu_iter_ctrl #(.Z(Z), .DRAIN(D), .MAX_ITER(MI)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .syndrome_ok_i(syn), .addr_en_o(addr_en), .first_iter_o(first_iter),
    .busy_o(busy), .done_o(done), .success_o(success), .iter_cnt_o(iter_cnt)
  );

  // Reference model: mode 0 idle, 1 iterating, 2 done pulse. While iterating,
  // m_t counts cycles since the accepted start (1 = first sweep cycle); the
  // position inside an iteration follows from m_t modulo the period.
  int m_mode, m_t, m_iter;
  bit m_succ;

  // Per-scenario observations; cycle n is the cycle after edge n-1.
  int ecnt, done_cyc, busy_fall, en_cnt, en_first, en_last, fi_cnt, fi_last, en2;
  int iter_at_done;
  bit succ_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_iter = 0; m_succ = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit sy);
    int off;
    off = ((m_t - 1) % P) + 1;
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_t = 1; m_iter = 0; m_succ = 0; end
    end else if (ab) begin
      model_reset();
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (off == P) begin
      m_succ = sy;
      if (sy || m_iter == MI - 1) m_mode = 2;
      else begin m_iter++; m_t++; end
    end else begin
      m_t++;
    end
  endtask

  task automatic check_model();
    bit e_en;
    e_en = (m_mode == 1) && ((((m_t - 1) % P) + 1) <= Z);
    chk("addr_en",    32'(addr_en),    32'(e_en));
    chk("first_iter", 32'(first_iter), 32'(e_en && m_iter == 0));
    chk("busy",       32'(busy),       32'(m_mode != 0));
    chk("done",       32'(done),       32'(m_mode == 2));
    chk("success",    32'(success),    32'(m_succ));
    chk("iter_cnt",   32'(iter_cnt),   32'(m_iter));
  endtask

  task automatic cyc(input bit st, input bit ab, input bit sy);
    start = st; abort = ab; syn = sy;
    @(posedge clk);
    model_edge(st, ab, sy);
    ecnt++;
    @(negedge clk);
    check_model();
    if (done && done_cyc < 0) begin
      done_cyc = ecnt; iter_at_done = int'(iter_cnt); succ_at_done = success;
    end
    if (!busy && ecnt > 1 && busy_fall < 0) busy_fall = ecnt;
    if (addr_en) begin
      en_cnt++; en_last = ecnt;
      if (en_first < 0) en_first = ecnt;
      if (done_cyc >= 0 && en2 < 0) en2 = ecnt;
    end
    if (first_iter) begin fi_cnt++; fi_last = ecnt; end
  endtask

  // start at edge 0 plus optional extra starts; syndrome high at edge syn_at
  // (99 = every edge); abort at edge ab_at.
  task automatic scen(input int n, input int syn_at, input int ab_at,
                      input int s2, input int s3, input int s4);
    ecnt = 0; done_cyc = -1; busy_fall = -1; en_cnt = 0; en_first = -1;
    en_last = -1; fi_cnt = 0; fi_last = -1; en2 = -1; iter_at_done = -1;
    succ_at_done = 0;
    for (int e = 0; e < n; e++)
      cyc(e == 0 || e == s2 || e == s3 || e == s4, e == ab_at,
          syn_at == 99 || e == syn_at);
  endtask

  task automatic settle();
    for (int i = 0; i < 3 * P; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    check_model();
    chk("reset_iter", 32'(iter_cnt), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);  // abort in IDLE does nothing

    // Success on the first check.
    scen(12, 99, -1, -1, -1, -1);
    chk("s1_en_first", 32'(en_first), 32'd1);
    chk("s1_en_last",  32'(en_last),  32'd4);
    chk("s1_done_cyc", 32'(done_cyc), 32'd8);
    chk("s1_success",  32'(succ_at_done), 32'd1);
    chk("s1_iter",     32'(iter_at_done), 32'd0);
    chk("s1_busy_low", 32'(busy_fall), 32'd9);

    // Iteration limit.
    scen(26, -1, -1, -1, -1, -1);
    chk("s2_en_cnt",   32'(en_cnt),  32'd12);
    chk("s2_en_last",  32'(en_last), 32'd18);
    chk("s2_fi_cnt",   32'(fi_cnt),  32'd4);
    chk("s2_fi_last",  32'(fi_last), 32'd4);
    chk("s2_done_cyc", 32'(done_cyc), 32'd22);
    chk("s2_success",  32'(succ_at_done), 32'd0);
    chk("s2_iter",     32'(iter_at_done), 32'd2);

    // Early termination in the second check.
    scen(18, 14, -1, -1, -1, -1);
    chk("s3_done_cyc", 32'(done_cyc), 32'd15);
    chk("s3_iter",     32'(iter_at_done), 32'd1);
    chk("s3_success",  32'(succ_at_done), 32'd1);

    // Starts while busy are dropped; a start after done runs again.
    scen(30, -1, -1, 3, 8, 24);
    chk("s4_done_cyc", 32'(done_cyc), 32'd22);
    chk("s4_en_cnt",   32'(en_cnt),   32'd16);
    chk("s4_restart",  32'(en2),      32'd25);
    settle();

    // Abort in the second sweep.
    scen(16, -1, 10, -1, -1, -1);
    chk("s5_busy_low", 32'(busy_fall), 32'd11);
    chk("s5_en_last",  32'(en_last),   32'd10);
    chk("s5_no_done",  32'(done_cyc),  32'hFFFF_FFFF);
    chk("s5_iter",     32'(iter_cnt),  32'd0);
    chk("s5_success",  32'(success),   32'd0);

    // Asynchronous reset in the middle of DRAIN (cycle 6).
    scen(6, -1, -1, -1, -1, -1);
    chk("s6_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("s6_idle_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
